// File: rtl/gen_gamma_encoder.sv
// ---------------------------------------------------------------------------
// gen_gamma_encoder
//
// Gamma (additive-noise) encoder. A Galois LFSR produces a SIZE-bit noise
// key; every accepted plaintext word is added to the key of its own slot,
// and the carry is kept in a SIZE+1-bit mix word. The matching decoder
// subtracts noise_key from mix_data to get the plaintext back exactly.
//
// Two-stage valid/ready pipeline:
//   stage 1 : captures the plaintext word and the current LFSR key
//   stage 2 : output registers holding mix_data / noise_key
// Throughput is one word per clock while out_ready stays high.
//
// Optional build macro:
//   GEN_GAMMA_PARITY_EN - adds the mix_parity output, the XOR of all
//                         mix_data bits, registered alongside mix_data.
//
// Ports:
//   clk        in   1       clock, rising edge
//   res_n      in   1       asynchronous active-low reset
//   orig_data  in   SIZE    plaintext word
//   in_valid   in   1       orig_data valid
//   in_ready   out  1       encoder can accept a word
//   seed       in   SIZE    new LFSR seed
//   seed_load  in   1       load seed into the LFSR this cycle
//   mix_data   out  SIZE+1  orig + key, carry kept
//   noise_key  out  SIZE    key used for this mix_data word
//   out_valid  out  1       mix_data / noise_key valid
//   out_ready  in   1       downstream accepts the word
//   mix_parity out  1       (GEN_GAMMA_PARITY_EN only) ^mix_data
// ---------------------------------------------------------------------------
module gen_gamma_encoder #(
    parameter int              SIZE = 8,
    parameter logic [SIZE-1:0] POLY = 8'hB8,
    parameter logic [SIZE-1:0] SEED = 8'h01
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic [SIZE-1:0] orig_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] seed,
    input  logic            seed_load,
    output logic [SIZE:0]   mix_data,
    output logic [SIZE-1:0] noise_key,
    output logic            out_valid,
`ifdef GEN_GAMMA_PARITY_EN
    output logic            mix_parity,
`endif
    input  logic            out_ready
);

    // One Galois shift: feedback mask is applied when the bit shifted out is 1.
    function automatic logic [SIZE-1:0] lfsr_step(input logic [SIZE-1:0] cur);
        logic [SIZE-1:0] sh;
        sh = cur >> 1;
        return cur[0] ? (sh ^ POLY) : sh;
    endfunction

    // A zero seed would lock the LFSR up, so it is replaced by 1.
    function automatic logic [SIZE-1:0] seed_fix(input logic [SIZE-1:0] s);
        return (s == '0) ? SIZE'(1) : s;
    endfunction

    // Widen both operands first so the carry lands in the top bit.
    function automatic logic [SIZE:0] mix_add(input logic [SIZE-1:0] d,
                                              input logic [SIZE-1:0] k);
        return {1'b0, d} + {1'b0, k};
    endfunction

    logic [SIZE-1:0] lfsr_q;

    logic [SIZE-1:0] data_p1;
    logic [SIZE-1:0] key_p1;
    logic            vld_p1;

    logic [SIZE:0]   mix_p2;
    logic [SIZE-1:0] key_p2;
    logic            vld_p2;

    logic            load_p2;
    logic            accept;

    assign load_p2  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || load_p2;
    assign accept   = in_valid && in_ready;

    // Key generator: advances only on an accepted word; a seed load wins.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lfsr_q <= SEED;
        end else if (seed_load) begin
            lfsr_q <= seed_fix(seed);
        end else if (accept) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    // ---- stage 1 : capture plaintext and the key of its slot ----
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (load_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= orig_data;
            key_p1  <= lfsr_q;
        end
    end

    // ---- stage 2 : output registers, updated only when they move ----
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vld_p2 <= 1'b0;
            mix_p2 <= '0;
            key_p2 <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mix_p2 <= mix_add(data_p1, key_p1);
                key_p2 <= key_p1;
            end
        end
    end

`ifdef GEN_GAMMA_PARITY_EN
    logic par_p2;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            par_p2 <= 1'b0;
        end else if (load_p2 && vld_p1) begin
            par_p2 <= ^mix_add(data_p1, key_p1);
        end
    end

    assign mix_parity = par_p2;
`endif

    assign mix_data  = mix_p2;
    assign noise_key = key_p2;
    assign out_valid = vld_p2;

endmodule
